// File: rtl/write_through_buffer.sv
// Write-through store queue: buffers word stores from cache control in FIFO
// order and hands them one at a time to the AXI write channel. The head entry
// is copied into output registers on the pop edge so the write channel sees
// stable addr/wdata/wstrb for the whole transaction, even while pushes continue.
module write_through_buffer #(
  parameter int unsigned FE_ADDR_W = 32,
  parameter int unsigned FE_DATA_W = 32,
  parameter int unsigned FE_NBYTES = FE_DATA_W / 8,
  parameter int unsigned FE_BYTE_W = $clog2(FE_NBYTES),
  parameter int unsigned DEPTH_W   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  // Store enqueue from cache control
  input  logic                           push_i,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0] push_addr_i,
  input  logic [FE_DATA_W-1:0]           push_wdata_i,
  input  logic [FE_NBYTES-1:0]           push_wstrb_i,
  // Fill status
  output logic                           full_o,
  output logic                           empty_o,
  output logic [DEPTH_W:0]               level_o,
  output logic                           overflow_o,
  // Write channel side
  output logic                           valid_o,
  output logic [FE_ADDR_W-FE_BYTE_W-1:0] addr_o,
  output logic [FE_DATA_W-1:0]           wdata_o,
  output logic [FE_NBYTES-1:0]           wstrb_o,
  input  logic                           ready_i
);

  localparam int unsigned AddrW  = FE_ADDR_W - FE_BYTE_W;
  localparam int unsigned Depth  = 2 ** DEPTH_W;
  localparam int unsigned LevelW = DEPTH_W + 1;

  // Queue storage; deliberately not reset.
  logic [AddrW-1:0]     addr_mem  [Depth];
  logic [FE_DATA_W-1:0] wdata_mem [Depth];
  logic [FE_NBYTES-1:0] wstrb_mem [Depth];

  logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]    level_q, level_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 overflow_q, overflow_d;
  logic [AddrW-1:0]     addr_q, addr_d;
  logic [FE_DATA_W-1:0] wdata_q, wdata_d;
  logic [FE_NBYTES-1:0] wstrb_q, wstrb_d;

  logic pop;
  logic push_acc;

  // Handshake decode: a pop frees a slot in the same cycle, so a push into a
  // full queue is still accepted when the head leaves simultaneously.
  always_comb begin
    pop      = ~empty_q & ready_i;
    push_acc = push_i & (~full_q | pop);
  end

  // Next-state for pointers, occupancy, flags and the output registers.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;

    level_d = level_q + LevelW'(push_acc) - LevelW'(pop);
    empty_d = (level_d == '0);
    full_d  = (level_d == LevelW'(Depth));

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push_i & ~push_acc) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_mem[rd_ptr_q];
      wdata_d  = wdata_mem[rd_ptr_q];
      wstrb_d  = wstrb_mem[rd_ptr_q];
    end
  end

  // Control and output state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // Storage write; on push+pop while full this overwrites the slot whose old
  // contents are being copied to the output registers on the same edge.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      addr_mem[wr_ptr_q]  <= push_addr_i;
      wdata_mem[wr_ptr_q] <= push_wdata_i;
      wstrb_mem[wr_ptr_q] <= push_wstrb_i;
    end
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign valid_o    = ~empty_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = wstrb_q;

endmodule
